// File: rtl/wb_mem_2_ppfifo_pkg.sv
// Shared definitions for the memory-to-ppfifo reader: the host register map it has in common
// with the FIFO-to-memory writer, the per-bank configuration record and the buffer pick helper.
package wb_mem_2_ppfifo_pkg;

  localparam int REG_CONTROL    = 0;
  localparam int REG_STATUS     = 1;
  localparam int REG_MEM_0_BASE = 2;
  localparam int REG_MEM_0_SIZE = 3;
  localparam int REG_MEM_1_BASE = 4;
  localparam int REG_MEM_1_SIZE = 5;

  localparam int DEFAULT_FIFO_SIZE_WIDTH = 24;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] size;
  } bank_cfg_t;

  // Claim the lowest-numbered ppfifo write buffer that is ready.
  function automatic logic [1:0] pick_fifo(input logic [1:0] rdy);
    if (rdy[0])      return 2'b01;
    else if (rdy[1]) return 2'b10;
    else             return 2'b00;
  endfunction

endpackage

// File: rtl/wb_mem_2_ppfifo_if.sv
// Wishbone read-master bus plus ppfifo write port, bundled for the memory-to-ppfifo reader.
interface wb_mem_2_ppfifo_if #(
  parameter int FIFO_SIZE_WIDTH = 24
);

  logic                       mem_we;
  logic                       mem_stb;
  logic                       mem_cyc;
  logic [3:0]                 mem_sel;
  logic [31:0]                mem_adr;
  logic [31:0]                mem_wr_dat;
  logic [31:0]                mem_rd_dat;
  logic                       mem_ack;
  logic                       mem_int;

  logic [1:0]                 ppfifo_rdy;
  logic [1:0]                 ppfifo_act;
  logic [FIFO_SIZE_WIDTH-1:0] ppfifo_size;
  logic                       ppfifo_stb;
  logic [31:0]                ppfifo_data;

  modport master (
    output mem_we, mem_stb, mem_cyc, mem_sel, mem_adr, mem_wr_dat,
    input  mem_rd_dat, mem_ack, mem_int,
    input  ppfifo_rdy, ppfifo_size,
    output ppfifo_act, ppfifo_stb, ppfifo_data
  );

  modport slave (
    input  mem_we, mem_stb, mem_cyc, mem_sel, mem_adr, mem_wr_dat,
    output mem_rd_dat, mem_ack, mem_int,
    output ppfifo_rdy, ppfifo_size,
    input  ppfifo_act, ppfifo_stb, ppfifo_data
  );

endinterface

// File: rtl/wb_mem_2_ppfifo_bank.sv
// Bookkeeping for one memory bank: latches base/size when armed, counts words read and
// reports empty once the bank has been fully drained.
import wb_mem_2_ppfifo_pkg::*;

module wb_mem_2_ppfifo_bank (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  bank_cfg_t   arm_cfg,
  input  logic        word_done,
  input  logic        complete,
  output bank_cfg_t   cfg,
  output logic [31:0] count,
  output logic        empty
);

  // A bank only accepts a new job while it is empty, so a pulse on the bank being read is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg   <= '0;
      count <= '0;
      empty <= 1'b1;
    end else if (empty && arm && (arm_cfg.size != 32'd0)) begin
      cfg   <= arm_cfg;
      count <= '0;
      empty <= 1'b0;
    end else begin
      if (word_done) count <= count + 32'd1;
      if (complete)  empty <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_2_ppfifo.sv
// Wishbone read master that drains two ping-pong memory banks, one word at a time,
// into the write side of a ping-pong FIFO.
import wb_mem_2_ppfifo_pkg::*;

module wb_mem_2_ppfifo #(
  parameter logic [31:0] DEFAULT_MEM_0_BASE = 32'h00000000,
  parameter logic [31:0] DEFAULT_MEM_1_BASE = 32'h00100000,
  parameter int          FIFO_SIZE_WIDTH    = DEFAULT_FIFO_SIZE_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,

  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_ready,
  output logic [31:0] o_memory_0_count,
  output logic        o_memory_0_empty,

  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_ready,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_1_empty,

  output logic [31:0] o_default_mem_0_base,
  output logic [31:0] o_default_mem_1_base,
  output logic        o_read_finished,

  wb_mem_2_ppfifo_if.master bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GET_FIFO = 2'd1;
  localparam logic [1:0] MEM_REQ  = 2'd2;
  localparam logic [1:0] WAIT_ACK = 2'd3;

  logic [1:0]                 state;
  logic                       cur_bank;
  logic                       next_bank;
  logic [FIFO_SIZE_WIDTH-1:0] fifo_cnt;
  logic                       act_release;

  logic                       mem_cyc_q;
  logic                       mem_stb_q;
  logic [3:0]                 mem_sel_q;
  logic [31:0]                mem_adr_q;
  logic [1:0]                 act_q;
  logic                       pp_stb_q;
  logic [31:0]                pp_data_q;
  logic                       finished_q;

  bank_cfg_t                  arm_cfg0, arm_cfg1;
  bank_cfg_t                  cfg0, cfg1, sel_cfg;
  logic [31:0]                count0, count1, sel_count;
  logic                       empty0, empty1;
  logic [1:0]                 armed;
  logic                       ack_take, last_word, fifo_full;
  logic                       word_done0, word_done1, complete0, complete1;
  logic                       unused_inputs;

  always_comb begin
    arm_cfg0      = '0;
    arm_cfg0.base = i_memory_0_base;
    arm_cfg0.size = i_memory_0_size;
    arm_cfg1      = '0;
    arm_cfg1.base = i_memory_1_base;
    arm_cfg1.size = i_memory_1_size;
  end

  wb_mem_2_ppfifo_bank u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .arm       (i_memory_0_ready),
    .arm_cfg   (arm_cfg0),
    .word_done (word_done0),
    .complete  (complete0),
    .cfg       (cfg0),
    .count     (count0),
    .empty     (empty0)
  );

  wb_mem_2_ppfifo_bank u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .arm       (i_memory_1_ready),
    .arm_cfg   (arm_cfg1),
    .word_done (word_done1),
    .complete  (complete1),
    .cfg       (cfg1),
    .count     (count1),
    .empty     (empty1)
  );

  assign armed      = {~empty1, ~empty0};
  assign sel_cfg    = cur_bank ? cfg1 : cfg0;
  assign sel_count  = cur_bank ? count1 : count0;
  assign ack_take   = (state == WAIT_ACK) && bus.mem_ack;
  assign last_word  = (sel_count + 32'd1) == sel_cfg.size;
  assign fifo_full  = (fifo_cnt + FIFO_SIZE_WIDTH'(1)) == bus.ppfifo_size;
  assign word_done0 = ack_take && !cur_bank;
  assign word_done1 = ack_take &&  cur_bank;
  assign complete0  = word_done0 && last_word;
  assign complete1  = word_done1 && last_word;

  // Buffer ownership is handed back one cycle after the final strobe, so every strobe
  // lands while the buffer is still held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_bank    <= 1'b0;
      next_bank   <= 1'b0;
      fifo_cnt    <= '0;
      act_release <= 1'b0;
      mem_cyc_q   <= 1'b0;
      mem_stb_q   <= 1'b0;
      mem_sel_q   <= 4'h0;
      mem_adr_q   <= '0;
      act_q       <= 2'b00;
      pp_stb_q    <= 1'b0;
      pp_data_q   <= '0;
      finished_q  <= 1'b0;
    end else begin
      pp_stb_q   <= 1'b0;
      finished_q <= 1'b0;
      if (act_release) begin
        act_q       <= 2'b00;
        act_release <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (i_enable && (armed != 2'b00)) begin
            cur_bank <= armed[next_bank] ? next_bank : ~next_bank;
            state    <= GET_FIFO;
          end
        end
        GET_FIFO: begin
          if ((act_q == 2'b00) && (bus.ppfifo_rdy != 2'b00)) begin
            act_q    <= pick_fifo(bus.ppfifo_rdy);
            fifo_cnt <= '0;
            state    <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          mem_cyc_q <= 1'b1;
          mem_stb_q <= 1'b1;
          mem_sel_q <= 4'hF;
          mem_adr_q <= sel_cfg.base + sel_count;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.mem_ack) begin
            mem_cyc_q <= 1'b0;
            mem_stb_q <= 1'b0;
            mem_sel_q <= 4'h0;
            pp_data_q <= bus.mem_rd_dat;
            pp_stb_q  <= 1'b1;
            fifo_cnt  <= fifo_cnt + FIFO_SIZE_WIDTH'(1);
            if (last_word) begin
              act_release <= 1'b1;
              finished_q  <= 1'b1;
              next_bank   <= ~next_bank;
              state       <= IDLE;
            end else if (fifo_full) begin
              act_release <= 1'b1;
              state       <= GET_FIFO;
            end else if (!i_enable) begin
              act_release <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= MEM_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_we      = 1'b0;
  assign bus.mem_wr_dat  = 32'd0;
  assign bus.mem_cyc     = mem_cyc_q;
  assign bus.mem_stb     = mem_stb_q;
  assign bus.mem_sel     = mem_sel_q;
  assign bus.mem_adr     = mem_adr_q;
  assign bus.ppfifo_act  = act_q;
  assign bus.ppfifo_stb  = pp_stb_q;
  assign bus.ppfifo_data = pp_data_q;

  assign o_memory_0_count     = count0;
  assign o_memory_1_count     = count1;
  assign o_memory_0_empty     = empty0;
  assign o_memory_1_empty     = empty1;
  assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
  assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;
  assign o_read_finished      = finished_q;

  // The memory interrupt line has no role in a polled single-word reader.
  assign unused_inputs = &{1'b0, bus.mem_int};

endmodule

// File: tb/tb_wb_mem_2_ppfifo.sv
// Self-checking bench for wb_mem_2_ppfifo: directed scenarios plus randomized bank jobs,
// checked against an expected-word queue built from each bank's base/size.
import wb_mem_2_ppfifo_pkg::*;

module tb_wb_mem_2_ppfifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [31:0] i_memory_0_base, i_memory_0_size, i_memory_1_base, i_memory_1_size;
  logic        i_memory_0_ready, i_memory_1_ready;
  logic [31:0] o_memory_0_count, o_memory_1_count;
  logic        o_memory_0_empty, o_memory_1_empty;
  logic [31:0] o_default_mem_0_base, o_default_mem_1_base;
  logic        o_read_finished;

  int          total = 0;
  int          bad = 0;
  int          fin_seen = 0;
  int          strobes = 0;
  int          act_len = 0;
  int          act_lens[$];
  logic [31:0] exp_q[$];
  logic [1:0]  prev_act = 2'b00;
  logic [1:0]  prev_rdy = 2'b00;
  logic        rdy_random = 1'b0;
  logic        mem_hold = 1'b0;
  logic        force_ack = 1'b0;
  logic        seen = 1'b0;

  always #5 clk = ~clk;

  wb_mem_2_ppfifo_if #(.FIFO_SIZE_WIDTH(24)) bus ();

  wb_mem_2_ppfifo #(
    .DEFAULT_MEM_0_BASE (32'h00000000),
    .DEFAULT_MEM_1_BASE (32'h00100000),
    .FIFO_SIZE_WIDTH    (24)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_enable             (i_enable),
    .i_memory_0_base      (i_memory_0_base),
    .i_memory_0_size      (i_memory_0_size),
    .i_memory_0_ready     (i_memory_0_ready),
    .o_memory_0_count     (o_memory_0_count),
    .o_memory_0_empty     (o_memory_0_empty),
    .i_memory_1_base      (i_memory_1_base),
    .i_memory_1_size      (i_memory_1_size),
    .i_memory_1_ready     (i_memory_1_ready),
    .o_memory_1_count     (o_memory_1_count),
    .o_memory_1_empty     (o_memory_1_empty),
    .o_default_mem_0_base (o_default_mem_0_base),
    .o_default_mem_1_base (o_default_mem_1_base),
    .o_read_finished      (o_read_finished),
    .bus                  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Memory: returns adr ^ A5A50000, acking on the second cycle a request is visible.
  always @(negedge clk) begin
    if (force_ack) begin
      bus.mem_ack    = 1'b1;
      bus.mem_rd_dat = 32'hDEADBEEF;
    end else if (bus.mem_cyc && bus.mem_stb && !bus.mem_ack && !mem_hold) begin
      if (seen) begin
        bus.mem_ack    = 1'b1;
        bus.mem_rd_dat = bus.mem_adr ^ 32'hA5A50000;
        seen           = 1'b0;
      end else begin
        seen = 1'b1;
      end
    end else begin
      bus.mem_ack = 1'b0;
      seen        = 1'b0;
    end
  end

  // Scoreboard: every strobe must be expected, in order, inside a held buffer.
  always @(negedge clk) begin
    if (bus.ppfifo_stb) begin
      strobes++;
      act_len++;
      checkOutput("stb_while_act", 32'(bus.ppfifo_act != 2'b00), 32'd1);
      checkOutput("stb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) checkOutput("stb_data", bus.ppfifo_data, exp_q.pop_front());
    end
    if ((prev_act == 2'b00) && (bus.ppfifo_act != 2'b00))
      checkOutput("act_pick", 32'(bus.ppfifo_act), prev_rdy[0] ? 32'd1 : 32'd2);
    if ((prev_act != 2'b00) && (bus.ppfifo_act != prev_act)) begin
      checkOutput("act_len_max", 32'(act_len <= int'(bus.ppfifo_size)), 32'd1);
      act_lens.push_back(act_len);
      act_len = 0;
    end
    prev_act = bus.ppfifo_act;
    prev_rdy = bus.ppfifo_rdy;
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
    if (rdy_random) bus.ppfifo_rdy = 2'($urandom_range(0, 3));
    if (o_read_finished) fin_seen++;
  endtask

  task automatic pushWords(input logic [31:0] base, input logic [31:0] size);
    for (int i = 0; i < int'(size); i++) exp_q.push_back((base + 32'(i)) ^ 32'hA5A50000);
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input logic [31:0] b0, input logic [31:0] s0,
                               input logic [31:0] b1, input logic [31:0] s1);
    i_memory_0_base  = b0;
    i_memory_0_size  = s0;
    i_memory_1_base  = b1;
    i_memory_1_size  = s1;
    i_memory_0_ready = mask[0];
    i_memory_1_ready = mask[1];
    stepClk();
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int target, input int budget);
    int n = 0;
    while ((fin_seen < target) && (n < budget)) begin
      stepClk();
      n++;
    end
    checkOutput(tag, 32'(fin_seen), 32'(target));
    repeat (4) stepClk();
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    i_enable = 1'b0;
    repeat (3) stepClk();
    rst = 1'b0;
    stepClk();
    exp_q.delete();
    act_lens.delete();
    act_len  = 0;
    fin_seen = 0;
    strobes  = 0;
  endtask

  initial begin
    int          n;
    int          k;
    logic        flag;
    logic [31:0] b0, s0, b1, s1;

    rst = 1'b1;
    i_enable = 1'b0;
    i_memory_0_base = '0; i_memory_0_size = '0; i_memory_0_ready = 1'b0;
    i_memory_1_base = '0; i_memory_1_size = '0; i_memory_1_ready = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rd_dat = '0; bus.mem_int = 1'b0;
    bus.ppfifo_rdy = 2'b11; bus.ppfifo_size = 24'd4;
    $display("[TB] starting");
    resetDut();

    // 1: reset values, then a bank armed with enable low must not start the bus
    checkOutput("rst_cyc", 32'(bus.mem_cyc), 32'd0);
    checkOutput("rst_stb", 32'(bus.mem_stb), 32'd0);
    checkOutput("rst_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_sel", 32'(bus.mem_sel), 32'd0);
    checkOutput("rst_adr", bus.mem_adr, 32'd0);
    checkOutput("rst_wdat", bus.mem_wr_dat, 32'd0);
    checkOutput("rst_act", 32'(bus.ppfifo_act), 32'd0);
    checkOutput("rst_ppstb", 32'(bus.ppfifo_stb), 32'd0);
    checkOutput("rst_ppdata", bus.ppfifo_data, 32'd0);
    checkOutput("rst_count0", o_memory_0_count, 32'd0);
    checkOutput("rst_count1", o_memory_1_count, 32'd0);
    checkOutput("rst_empty", 32'({o_memory_1_empty, o_memory_0_empty}), 32'd3);
    checkOutput("rst_finished", 32'(o_read_finished), 32'd0);
    checkOutput("default_base0", o_default_mem_0_base, 32'h00000000);
    checkOutput("default_base1", o_default_mem_1_base, 32'h00100000);
    applyStimulus(2'b01, 32'h100, 32'd4, 32'h0, 32'd0);
    pushWords(32'h100, 32'd4);
    applyStimulus(2'b10, 32'h0, 32'd0, 32'h700, 32'd0);
    flag = 1'b0;
    repeat (20) begin
      stepClk();
      flag = flag | bus.mem_cyc;
    end
    checkOutput("t1_no_cyc", 32'(flag), 32'd0);
    checkOutput("t1_armed0", 32'(o_memory_0_empty), 32'd0);
    checkOutput("t1_size0_ignored", 32'(o_memory_1_empty), 32'd1);

    // 2: single bank fits one buffer
    i_enable = 1'b1;
    waitDone("t2_finish", 1, 200);
    checkOutput("t2_count0", o_memory_0_count, 32'd4);
    checkOutput("t2_empty0", 32'(o_memory_0_empty), 32'd1);
    checkOutput("t2_fin_once", 32'(fin_seen), 32'd1);
    checkOutput("t2_strobes", 32'(strobes), 32'd4);
    checkOutput("t2_left", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_act_idle", 32'(bus.ppfifo_act), 32'd0);

    // 3: ten words split 4/4/2; re-arm of the active bank is ignored
    resetDut();
    applyStimulus(2'b01, 32'h300, 32'd10, 32'h0, 32'd0);
    pushWords(32'h300, 32'd10);
    i_enable = 1'b1;
    repeat (5) stepClk();
    applyStimulus(2'b01, 32'h900, 32'd2, 32'h0, 32'd0);
    waitDone("t3_finish", 1, 400);
    checkOutput("t3_count0", o_memory_0_count, 32'd10);
    checkOutput("t3_left", 32'(exp_q.size()), 32'd0);
    checkOutput("t3_nact", 32'(act_lens.size()), 32'd3);
    if (act_lens.size() == 3) begin
      checkOutput("t3_len0", 32'(act_lens[0]), 32'd4);
      checkOutput("t3_len1", 32'(act_lens[1]), 32'd4);
      checkOutput("t3_len2", 32'(act_lens[2]), 32'd2);
    end

    // 4: both banks armed in the same cycle
    resetDut();
    i_enable = 1'b1;
    applyStimulus(2'b11, 32'h0, 32'd3, 32'h200, 32'd2);
    pushWords(32'h0, 32'd3);
    pushWords(32'h200, 32'd2);
    waitDone("t4_finish", 2, 400);
    checkOutput("t4_count0", o_memory_0_count, 32'd3);
    checkOutput("t4_count1", o_memory_1_count, 32'd2);
    checkOutput("t4_empty", 32'({o_memory_1_empty, o_memory_0_empty}), 32'd3);
    checkOutput("t4_left", 32'(exp_q.size()), 32'd0);

    // 5: enable drops after the second word; the read in flight still lands
    resetDut();
    applyStimulus(2'b01, 32'h400, 32'd8, 32'h0, 32'd0);
    pushWords(32'h400, 32'd8);
    i_enable = 1'b1;
    n = 0;
    k = 0;
    while ((n < 2) && (k < 200)) begin
      stepClk();
      if (bus.ppfifo_stb) n++;
      k++;
    end
    checkOutput("t5_two_words", 32'(n), 32'd2);
    i_enable = 1'b0;
    repeat (20) stepClk();
    checkOutput("t5_stop_cyc", 32'(bus.mem_cyc), 32'd0);
    checkOutput("t5_stop_act", 32'(bus.ppfifo_act), 32'd0);
    checkOutput("t5_stop_count", o_memory_0_count, 32'd3);
    checkOutput("t5_still_armed", 32'(o_memory_0_empty), 32'd0);
    i_enable = 1'b1;
    waitDone("t5_finish", 1, 400);
    checkOutput("t5_count0", o_memory_0_count, 32'd8);
    checkOutput("t5_left", 32'(exp_q.size()), 32'd0);
    checkOutput("t5_nact", 32'(act_lens.size()), 32'd3);
    if (act_lens.size() == 3) begin
      checkOutput("t5_len0", 32'(act_lens[0]), 32'd3);
      checkOutput("t5_len1", 32'(act_lens[1]), 32'd4);
      checkOutput("t5_len2", 32'(act_lens[2]), 32'd1);
    end

    // 6: reset while a read is outstanding, then a stray ack
    resetDut();
    mem_hold = 1'b1;
    applyStimulus(2'b01, 32'h500, 32'd4, 32'h0, 32'd0);
    i_enable = 1'b1;
    k = 0;
    while (!bus.mem_cyc && (k < 100)) begin
      stepClk();
      k++;
    end
    checkOutput("t6_cyc_up", 32'(bus.mem_cyc), 32'd1);
    repeat (2) stepClk();
    rst = 1'b1;
    stepClk();
    checkOutput("t6_cyc", 32'(bus.mem_cyc), 32'd0);
    checkOutput("t6_stb", 32'(bus.mem_stb), 32'd0);
    checkOutput("t6_act", 32'(bus.ppfifo_act), 32'd0);
    rst = 1'b0;
    i_enable = 1'b0;
    force_ack = 1'b1;
    stepClk();
    force_ack = 1'b0;
    mem_hold = 1'b0;
    flag = 1'b0;
    repeat (6) begin
      stepClk();
      flag = flag | bus.ppfifo_stb | bus.mem_cyc;
    end
    checkOutput("t6_quiet", 32'(flag), 32'd0);
    checkOutput("t6_count0", o_memory_0_count, 32'd0);
    checkOutput("t6_empty", 32'({o_memory_1_empty, o_memory_0_empty}), 32'd3);

    // 7: random bank jobs with random buffer size and buffer availability
    resetDut();
    bus.ppfifo_size = 24'($urandom_range(1, 4));
    rdy_random = 1'b1;
    i_enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      b0 = (r == 0) ? 32'hFFFFFFFE : $urandom;
      s0 = 32'($urandom_range(1, 9));
      b1 = $urandom;
      s1 = 32'($urandom_range(1, 9));
      applyStimulus(2'b11, b0, s0, b1, s1);
      pushWords(b0, s0);
      pushWords(b1, s1);
      waitDone("t7_finish", 2 * (r + 1), 3000);
      checkOutput("t7_count0", o_memory_0_count, s0);
      checkOutput("t7_count1", o_memory_1_count, s1);
      checkOutput("t7_empty", 32'({o_memory_1_empty, o_memory_0_empty}), 32'd3);
      checkOutput("t7_left", 32'(exp_q.size()), 32'd0);
    end
    rdy_random = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
